// File: rtl/uart_packet_parser.sv
// Frames the UART receive byte stream into header + payload transactions.
// Flags illegal opcodes, illegal lengths and inter-byte stalls on err_o / err_code_o.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for the opcode byte
// RSVD    | waiting for the reserved byte
// LEN_LO  | waiting for length[7:0]
// LEN_HI  | waiting for length[15:8]
// CHECK   | validate length then opcode (one cycle, no byte accepted)
// CMD     | header presented on cmd_*, waiting for consumer
// PAYLOAD | bytes pass straight through to pl_*
// DROP    | discarding the payload of a packet with an illegal opcode
module uart_packet_parser #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [15:0] MAX_LEN        = 16'h0104
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  cmd_opcode_o,
    output logic [15:0] cmd_len_o,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    output logic [7:0]  pl_data_o,
    output logic        pl_valid_o,
    output logic        pl_last_o,
    input  logic        pl_ready_i,
    output logic        err_o,
    output logic [1:0]  err_code_o
);

    localparam int unsigned   TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        RSVD,
        LEN_LO,
        LEN_HI,
        CHECK,
        CMD,
        PAYLOAD,
        DROP
    } state_t;

    state_t          state;
    logic [15:0]     len_q;
    logic [15:0]     count;
    logic [TW-1:0]   timer;
    logic            rx_fire;
    logic            timer_active;
    logic            timer_hold;
    logic            timer_expire;
    logic            opcode_ok;

    always_comb begin
        rx_ready_o = 1'b0;
        case (state)
            IDLE, RSVD, LEN_LO, LEN_HI: rx_ready_o = 1'b1;
            // A zero-length drop must not swallow the next packet's opcode
            DROP:                       rx_ready_o = (count != 16'd0);
            PAYLOAD:                    rx_ready_o = pl_ready_i;
            default:                    rx_ready_o = 1'b0;
        endcase
    end

    assign rx_fire    = rx_valid_i && rx_ready_o;
    assign pl_valid_o = (state == PAYLOAD) && rx_valid_i;
    assign pl_data_o  = (state == PAYLOAD) ? rx_data_i : 8'h00;
    assign pl_last_o  = (state == PAYLOAD) && (count == 16'd1);

    assign opcode_ok = (cmd_opcode_o == 8'hEC) || (cmd_opcode_o == 8'h88) ||
                       (cmd_opcode_o == 8'h89) || (cmd_opcode_o == 8'h8A);

    assign timer_active = (state == RSVD) || (state == LEN_LO) || (state == LEN_HI) ||
                          (state == PAYLOAD) || (state == DROP);
    // Consumer backpressure is not a stall on the UART side
    assign timer_hold   = rx_fire || ((state == PAYLOAD) && !pl_ready_i);
    assign timer_expire = timer_active && !timer_hold && (timer == TW'(1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state        <= IDLE;
            len_q        <= 16'd0;
            count        <= 16'd0;
            timer        <= '0;
            cmd_opcode_o <= 8'h00;
            cmd_len_o    <= 16'd0;
            cmd_valid_o  <= 1'b0;
            err_o        <= 1'b0;
            err_code_o   <= 2'd0;
        end else begin
            err_o <= 1'b0;

            // Preloaded while inactive, so every entry to a timed state starts fresh
            if (!timer_active || timer_hold) begin
                timer <= TIMER_LOAD;
            end else if (timer != '0) begin
                timer <= timer - TW'(1);
            end

            if (timer_expire) begin
                state       <= IDLE;
                cmd_valid_o <= 1'b0;
                err_o       <= 1'b1;
                err_code_o  <= 2'd3;
            end else begin
                case (state)
                    IDLE: begin
                        if (rx_fire) begin
                            cmd_opcode_o <= rx_data_i;
                            state        <= RSVD;
                        end
                    end
                    RSVD: begin
                        if (rx_fire) state <= LEN_LO;
                    end
                    LEN_LO: begin
                        if (rx_fire) begin
                            len_q[7:0] <= rx_data_i;
                            state      <= LEN_HI;
                        end
                    end
                    LEN_HI: begin
                        if (rx_fire) begin
                            len_q[15:8] <= rx_data_i;
                            state       <= CHECK;
                        end
                    end
                    CHECK: begin
                        if ((len_q < 16'd4) || (len_q > MAX_LEN)) begin
                            err_o      <= 1'b1;
                            err_code_o <= 2'd2;
                            state      <= IDLE;
                        end else if (!opcode_ok) begin
                            err_o      <= 1'b1;
                            err_code_o <= 2'd1;
                            count      <= len_q - 16'd4;
                            state      <= DROP;
                        end else begin
                            cmd_len_o   <= len_q - 16'd4;
                            count       <= len_q - 16'd4;
                            cmd_valid_o <= 1'b1;
                            state       <= CMD;
                        end
                    end
                    CMD: begin
                        if (cmd_ready_i) begin
                            cmd_valid_o <= 1'b0;
                            state       <= (cmd_len_o != 16'd0) ? PAYLOAD : IDLE;
                        end
                    end
                    PAYLOAD: begin
                        if (rx_fire) begin
                            count <= count - 16'd1;
                            if (count == 16'd1) state <= IDLE;
                        end
                    end
                    DROP: begin
                        if (count == 16'd0) begin
                            state <= IDLE;
                        end else if (rx_fire) begin
                            count <= count - 16'd1;
                            if (count == 16'd1) state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
